load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter: XLEN, 32, data and address width; only 32 is supported.
REQ-002 One clock, clk; reset is asynchronous and active-high, rst.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 rst  input  1  asynchronous active-high reset.
REQ-005 req_valid  input  1  pipeline MEM-stage access request.
REQ-006 req_ready  output  1  LSU can accept a request this cycle.
REQ-007 req_we  input  1  1 = store, 0 = load.
REQ-008 req_op  input  3  RISC-V funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-009 req_addr  input  32  byte address.
REQ-010 req_wdata  input  32  store data, right-aligned.
REQ-011 resp_valid  output  1  one-cycle completion pulse.
REQ-012 resp_rdata  output  32  load result, extended per req_op; 0 for stores and errors.
REQ-013 resp_err  output  1  qualifies resp_valid: access rejected.
REQ-014 mem_addr, mem_op, mem_wdata  output  32/3/32  drive DataMemory addr, MemOp, WriteData.
REQ-015 mem_read, mem_write  output  1/1  drive DataMemory MemRead, MemWrite.
REQ-016 mem_rdata  input  32  DataMemory ReadData; combinational read, valid in the cycle mem_read is high.

Function
REQ-017 States: IDLE, ACCESS, SPLIT, RESP; req_ready = 1 only in IDLE.
REQ-018 IDLE: on req_valid, register we/op/addr/wdata; go to ACCESS if aligned, SPLIT if misaligned and REQ-032 applies, else RESP with error.
REQ-019 Misaligned: H/HU with addr[0]=1; W with addr[1:0]!=0; B/BU never misaligned.
REQ-020 Illegal req_op (011, 110, 111) -> RESP with resp_err=1, no memory access, regardless of configuration.
REQ-021 ACCESS (one cycle): mem_addr=addr, mem_op=op, mem_read=!we, mem_write=we, mem_wdata=wdata; capture mem_rdata at the clock edge; go to RESP.
REQ-022 SPLIT: byte counter k = 0..N-1 (N=2 for H/HU, 4 for W); each cycle drives one byte access at addr+k with mem_op=000 (store) or 100 (load).
REQ-023 SPLIT store: mem_wdata = wdata >> (8*k); load: mem_rdata[7:0] captured into result byte k.
REQ-024 After byte N-1, the assembled load is sign-extended (H) or zero-extended (HU); W is unchanged; go to RESP.
REQ-025 Address arithmetic is 32-bit modulo; addr+k wraps 0xFFFFFFFF -> 0x00000000.
REQ-026 RESP: resp_valid=1 for exactly one cycle with the registered result/err, then IDLE.
REQ-027 mem_read and mem_write are 0 outside ACCESS/SPLIT and are never both 1.
REQ-028 Latency from accept edge to resp_valid: aligned 2 cycles; split N+1 cycles; error 1 cycle.
REQ-029 req_valid while busy is ignored; the pipeline holds the request until req_ready is high.

Reset
REQ-030 rst asserted: state=IDLE, counter=0, req_ready=1, resp_valid=0, resp_err=0, resp_rdata=0, mem_read=0, mem_write=0, mem_addr=0, mem_op=0, mem_wdata=0, all asynchronously.
REQ-031 Reset mid-SPLIT aborts the sequence: no further byte writes and no response; bytes already written remain written.

Configuration
REQ-032 Macro LSU_MISALIGN_SPLIT_EN defined: misaligned accesses execute via SPLIT. Undefined: misaligned accesses take RESP with resp_err=1 and no memory access; SPLIT logic is not compiled in.

Verification
REQ-033 Aligned store SW addr=0x0, wdata=0x000000FF, then LW addr=0x0 -> mem_write one cycle with mem_op=010; the load returns resp_rdata=0x000000FF two cycles after accept.
REQ-034 SH addr=0x2 wdata=0xEEEE, then LH addr=0x2 -> resp_rdata=0xFFFFEEEE; LHU addr=0x2 -> 0x0000EEEE.
REQ-035 With macro: SW addr=0x5 wdata=0x11223344 -> four byte writes 0x44,0x33,0x22,0x11 at 0x5..0x8; LW addr=0x5 -> 0x11223344, resp_valid five cycles after accept.
REQ-036 Without macro: LW addr=0x5 -> resp_valid and resp_err=1 one cycle after accept, resp_rdata=0, mem_read/mem_write never asserted.
REQ-037 req_op=011 at addr=0x4 -> resp_err=1 in both configurations; rst pulsed during the second byte of a split SW addr=0x1 -> only byte 0x1 written, no resp_valid, req_ready=1.

Source files
------------

// File: rtl/load_store_unit.sv
// Load/store unit: one access per request through a four-state FSM (IDLE, ACCESS, SPLIT, RESP).
// Define LSU_MISALIGN_SPLIT_EN to run misaligned H/W accesses as byte sequences; otherwise they are rejected.
module load_store_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_we,
    input  logic [2:0]      req_op,
    input  logic [XLEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_wdata,
    output logic            resp_valid,
    output logic [XLEN-1:0] resp_rdata,
    output logic            resp_err,
    output logic [XLEN-1:0] mem_addr,
    output logic [2:0]      mem_op,
    output logic [XLEN-1:0] mem_wdata,
    output logic            mem_read,
    output logic            mem_write,
    input  logic [XLEN-1:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, ACCESS, SPLIT, RESP} lsuState_t;

    lsuState_t state;
    logic      weReg;
    logic [2:0] opReg;
    logic      reqMisaligned;
    logic      reqError;

    function automatic logic isLegal(input logic [2:0] op);
        return (op == 3'b000) || (op == 3'b001) || (op == 3'b010) ||
               (op == 3'b100) || (op == 3'b101);
    endfunction

    function automatic logic isMisaligned(input logic [2:0] op, input logic [1:0] lo);
        logic result;
        case (op[1:0])
            2'b01:   result = lo[0];
            2'b10:   result = (lo != 2'b00);
            default: result = 1'b0;
        endcase
        return result;
    endfunction

    function automatic logic [XLEN-1:0] extendLoad(input logic [2:0] op, input logic [XLEN-1:0] raw);
        logic [XLEN-1:0] result;
        case (op)
            3'b000:  result = {{(XLEN-8){raw[7]}}, raw[7:0]};
            3'b100:  result = {{(XLEN-8){1'b0}}, raw[7:0]};
            3'b001:  result = {{(XLEN-16){raw[15]}}, raw[15:0]};
            3'b101:  result = {{(XLEN-16){1'b0}}, raw[15:0]};
            default: result = raw;
        endcase
        return result;
    endfunction

`ifdef LSU_MISALIGN_SPLIT_EN
    logic [1:0]      counter;
    logic [1:0]      nextCount;
    logic [XLEN-1:0] addrReg;
    logic [XLEN-1:0] wdataReg;
    logic [XLEN-1:0] splitBuf;
    logic [XLEN-1:0] assembled;

    function automatic logic [1:0] lastByte(input logic [2:0] op);
        return op[1] ? 2'd3 : 2'd1;
    endfunction

    // Load bytes land in the buffer lane selected by the byte counter.
    always_comb begin
        nextCount = counter + 2'd1;
        assembled = splitBuf;
        assembled[{counter, 3'b000} +: 8] = mem_rdata[7:0];
    end
`endif

    always_comb begin
        reqMisaligned = isMisaligned(req_op, req_addr[1:0]);
`ifdef LSU_MISALIGN_SPLIT_EN
        reqError = !isLegal(req_op);
`else
        reqError = !isLegal(req_op) || reqMisaligned;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= '0;
            mem_read   <= 1'b0;
            mem_write  <= 1'b0;
            mem_addr   <= '0;
            mem_op     <= '0;
            mem_wdata  <= '0;
`ifdef LSU_MISALIGN_SPLIT_EN
            counter    <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        weReg     <= req_we;
                        opReg     <= req_op;
                        req_ready <= 1'b0;
`ifdef LSU_MISALIGN_SPLIT_EN
                        addrReg   <= req_addr;
                        wdataReg  <= req_wdata;
                        splitBuf  <= '0;
`endif
                        if (reqError) begin
                            state      <= RESP;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                            resp_rdata <= '0;
`ifdef LSU_MISALIGN_SPLIT_EN
                        end else if (reqMisaligned) begin
                            state     <= SPLIT;
                            counter   <= '0;
                            mem_addr  <= req_addr;
                            mem_op    <= req_we ? 3'b000 : 3'b100;
                            mem_wdata <= req_wdata;
                            mem_read  <= !req_we;
                            mem_write <= req_we;
`endif
                        end else begin
                            state     <= ACCESS;
                            mem_addr  <= req_addr;
                            mem_op    <= req_op;
                            mem_wdata <= req_wdata;
                            mem_read  <= !req_we;
                            mem_write <= req_we;
                        end
                    end
                end
                ACCESS: begin
                    state      <= RESP;
                    resp_valid <= 1'b1;
                    resp_err   <= 1'b0;
                    resp_rdata <= weReg ? '0 : extendLoad(opReg, mem_rdata);
                    mem_read   <= 1'b0;
                    mem_write  <= 1'b0;
                end
`ifdef LSU_MISALIGN_SPLIT_EN
                SPLIT: begin
                    if (!weReg) splitBuf <= assembled;
                    if (counter == lastByte(opReg)) begin
                        state      <= RESP;
                        resp_valid <= 1'b1;
                        resp_err   <= 1'b0;
                        resp_rdata <= weReg ? '0 : extendLoad(opReg, assembled);
                        mem_read   <= 1'b0;
                        mem_write  <= 1'b0;
                    end else begin
                        counter   <= nextCount;
                        mem_addr  <= addrReg + XLEN'(nextCount);
                        mem_wdata <= wdataReg >> {nextCount, 3'b000};
                    end
                end
`endif
                RESP: begin
                    state      <= IDLE;
                    req_ready  <= 1'b1;
                    resp_valid <= 1'b0;
                    resp_err   <= 1'b0;
                    resp_rdata <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: little-endian byte memory behind the DUT, transaction-level reference model.
// Expectations follow LSU_MISALIGN_SPLIT_EN the same way the design does.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [2:0]  req_op = '0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] mem_addr;
    logic [2:0]  mem_op;
    logic [31:0] mem_wdata;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_rdata;

`ifdef LSU_MISALIGN_SPLIT_EN
    localparam bit SPLIT_EN = 1'b1;
`else
    localparam bit SPLIT_EN = 1'b0;
`endif

    load_store_unit #(.XLEN(32)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_op(req_op), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_addr(mem_addr), .mem_op(mem_op), .mem_wdata(mem_wdata),
        .mem_read(mem_read), .mem_write(mem_write), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] addr;
        logic [2:0]  op;
        logic [31:0] wdata;
    } wr_t;

    logic [7:0] devMem [64];
    logic [7:0] refMem [64];
    wr_t        writeLog [$];
    logic       bothSeen = 1'b0;
    int         checks = 0;
    int         errors = 0;

    // Data memory seen by the DUT: combinational read, extension done by the memory per MemOp.
    function automatic logic [31:0] devRead(input logic [31:0] a, input logic [2:0] op);
        logic [31:0] w;
        for (int i = 0; i < 4; i++) w[8*i +: 8] = devMem[6'(a[5:0] + 6'(i))];
        case (op)
            3'b000:  return {{24{w[7]}}, w[7:0]};
            3'b001:  return {{16{w[15]}}, w[15:0]};
            3'b100:  return {24'h0, w[7:0]};
            3'b101:  return {16'h0, w[15:0]};
            default: return w;
        endcase
    endfunction

    always_comb begin
        mem_rdata = '0;
        if (mem_read) mem_rdata = devRead(mem_addr, mem_op);
    end

    always @(posedge clk) begin
        if (mem_write) begin
            writeLog.push_back('{mem_addr, mem_op, mem_wdata});
            for (int i = 0; i < (mem_op[1] ? 4 : (mem_op[0] ? 2 : 1)); i++)
                devMem[6'(mem_addr[5:0] + 6'(i))] <= mem_wdata[8*i +: 8];
        end
        if (mem_read && mem_write) bothSeen <= 1'b1;
    end

    function automatic int nBytes(input logic [2:0] op);
        return op[1] ? 4 : (op[0] ? 2 : 1);
    endfunction

    function automatic bit legalOp(input logic [2:0] op);
        return op == 3'd0 || op == 3'd1 || op == 3'd2 || op == 3'd4 || op == 3'd5;
    endfunction

    function automatic logic [31:0] refLoad(input logic [2:0] op, input logic [31:0] addr);
        int n = nBytes(op);
        logic [31:0] v = 0;
        for (int i = 0; i < n; i++) v = v | (32'(refMem[(addr + 32'(i)) % 64]) << (8*i));
        if (op[2] == 1'b0 && n < 4 && v[8*n-1]) v = v | ~((32'd1 << (8*n)) - 32'd1);
        return v;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic doReq(input logic we, input logic [2:0] op, input logic [31:0] addr,
                         input logic [31:0] wdata, input string tag,
                         output logic [31:0] rdata, output logic err, output int lat,
                         output logic sawMem);
        logic found;
        writeLog.delete();
        @(negedge clk);
        check({tag, " ready"}, 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_we = we; req_op = op; req_addr = addr; req_wdata = wdata;
        @(posedge clk);
        #1;
        req_valid = 1'b0; req_we = 1'b0; req_op = '0; req_addr = '0; req_wdata = '0;
        lat = 0; found = 1'b0; sawMem = 1'b0; rdata = 'x; err = 1'bx;
        while (!found && lat < 12) begin
            @(negedge clk);
            lat++;
            if (mem_read || mem_write) sawMem = 1'b1;
            if (resp_valid) begin
                found = 1'b1;
                rdata = resp_rdata;
                err   = resp_err;
            end
        end
        if (!found) lat = 99;
        else begin
            @(negedge clk);
            check({tag, " pulse"}, 32'(resp_valid), 32'd0);
            check({tag, " rdyback"}, 32'(req_ready), 32'd1);
        end
    endtask

    task automatic runOp(input logic we, input logic [2:0] op, input logic [31:0] addr,
                         input logic [31:0] wdata, input string tag);
        logic [31:0] rdata, expData;
        logic        err, sawMem, expErr, isAligned;
        int          lat, expLat, n;
        n         = legalOp(op) ? nBytes(op) : 1;
        isAligned = (addr % n) == 0;
        expErr    = !legalOp(op) || (!isAligned && !SPLIT_EN);
        expLat    = expErr ? 1 : (isAligned ? 2 : n + 1);
        expData   = (expErr || we) ? 32'd0 : refLoad(op, addr);
        doReq(we, op, addr, wdata, tag, rdata, err, lat, sawMem);
        check({tag, " err"}, 32'(err), 32'(expErr));
        check({tag, " rdata"}, rdata, expData);
        check({tag, " lat"}, 32'(lat), 32'(expLat));
        if (expErr) check({tag, " nomem"}, 32'(sawMem), 32'd0);
        check({tag, " nwrites"}, 32'(writeLog.size()),
              32'((we && !expErr) ? (isAligned ? 1 : n) : 0));
        if (we && !expErr)
            for (int i = 0; i < n; i++) refMem[(addr + 32'(i)) % 64] = 8'(wdata >> (8*i));
    endtask

    initial begin
        for (int i = 0; i < 64; i++) refMem[i] = 8'h00;

        // Asynchronous reset, checked before any clock edge
        #1 rst = 1'b1;
        #1;
        check("rst req_ready", 32'(req_ready), 32'd1);
        check("rst resp_valid", 32'(resp_valid), 32'd0);
        check("rst resp_err", 32'(resp_err), 32'd0);
        check("rst resp_rdata", resp_rdata, 32'd0);
        check("rst mem_read", 32'(mem_read), 32'd0);
        check("rst mem_write", 32'(mem_write), 32'd0);
        check("rst mem_addr", mem_addr, 32'd0);
        check("rst mem_op", 32'(mem_op), 32'd0);
        check("rst mem_wdata", mem_wdata, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        runOp(1'b1, 3'b010, 32'h0, 32'h000000FF, "sw0");
        if (writeLog.size() == 1) begin
            check("sw0 mem_op", 32'(writeLog[0].op), 32'd2);
            check("sw0 mem_addr", writeLog[0].addr, 32'h0);
        end
        runOp(1'b0, 3'b010, 32'h0, 32'h0, "lw0");

        runOp(1'b1, 3'b001, 32'h2, 32'h0000EEEE, "sh2");
        runOp(1'b0, 3'b001, 32'h2, 32'h0, "lh2");
        runOp(1'b0, 3'b101, 32'h2, 32'h0, "lhu2");

        runOp(1'b1, 3'b010, 32'h5, 32'h11223344, "sw5");
        if (SPLIT_EN && writeLog.size() == 4) begin
            for (int k = 0; k < 4; k++) begin
                check($sformatf("sw5 addr%0d", k), writeLog[k].addr, 32'h5 + 32'(k));
                check($sformatf("sw5 op%0d", k), 32'(writeLog[k].op), 32'd0);
                check($sformatf("sw5 byte%0d", k), 32'(writeLog[k].wdata[7:0]),
                      32'(8'(32'h11223344 >> (8*k))));
            end
        end
        runOp(1'b0, 3'b010, 32'h5, 32'h0, "lw5");

        runOp(1'b0, 3'b011, 32'h4, 32'h0, "op011");
        runOp(1'b1, 3'b111, 32'h4, 32'hDEADBEEF, "op111");

        runOp(1'b1, 3'b001, 32'hFFFFFFFF, 32'h0000A55A, "shwrap");
        runOp(1'b0, 3'b101, 32'hFFFFFFFF, 32'h0, "lhuwrap");

`ifdef LSU_MISALIGN_SPLIT_EN
        // Reset while the second byte of a split store is on the bus
        writeLog.delete();
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_op = 3'b010; req_addr = 32'h1; req_wdata = 32'hA1B2C3D4;
        @(posedge clk);
        #1 req_valid = 1'b0; req_we = 1'b0; req_op = '0; req_addr = '0; req_wdata = '0;
        @(negedge clk);
        @(negedge clk);
        check("abort addr", mem_addr, 32'h2);
        rst = 1'b1;
        #2 rst = 1'b0;
        check("abort ready", 32'(req_ready), 32'd1);
        check("abort mem_write", 32'(mem_write), 32'd0);
        begin
            logic sawResp = 1'b0;
            repeat (4) begin
                @(negedge clk);
                if (resp_valid) sawResp = 1'b1;
            end
            check("abort noresp", 32'(sawResp), 32'd0);
        end
        check("abort nwrites", 32'(writeLog.size()), 32'd1);
        if (writeLog.size() == 1) check("abort wr addr", writeLog[0].addr, 32'h1);
        refMem[1] = 8'hD4;
        runOp(1'b0, 3'b010, 32'h0, 32'h0, "lwafter");
`endif

        for (int i = 0; i < 60; i++) begin
            logic [2:0]  op;
            logic [31:0] addr;
            logic        we;
            if ($urandom_range(0, 7) == 0) op = 3'($urandom_range(3, 7) | 3);
            else begin
                case ($urandom_range(0, 4))
                    0: op = 3'b000;
                    1: op = 3'b001;
                    2: op = 3'b010;
                    3: op = 3'b100;
                    default: op = 3'b101;
                endcase
            end
            if ($urandom_range(0, 5) == 0) addr = 32'hFFFFFFFC + 32'($urandom_range(0, 3));
            else addr = 32'($urandom_range(0, 63));
            we = (i < 15) ? 1'b1 : 1'($urandom_range(0, 1));
            runOp(we, op, addr, $urandom, $sformatf("rnd%0d", i));
        end

        check("never both", 32'(bothSeen), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
